// File: rtl/rtc_bus_bridge.sv
// rtl/rtc_bus_bridge.sv - PicoBlaze port-mapped bridge to a multiplexed address/data RTC bus
//
// Purpose: exposes ADDR/WDATA/CMD/STATUS/RDATA ports at BASE..BASE+4 and runs one
// six-phase bus transaction (address set/strobe/hold, data set/strobe/hold) per start.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   port_id, out_port            PicoBlaze address and write data
//   write_strobe, read_strobe    PicoBlaze qualifiers (reads have no side effects)
//   in_port                      registered read data back to PicoBlaze
//   rtc_ad_o, rtc_ad_oe, rtc_ad_i multiplexed bus: driven value, enable, sampled value
//   rtc_cs_n, rtc_rd_n, rtc_wr_n active-low chip select / read / write strobes
//   rtc_a_d                      0 = address phase, 1 = data phase
module rtc_bus_bridge #(
    parameter int unsigned T_PH = 4,
    parameter logic [7:0]  BASE = 8'h10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic [7:0] rtc_ad_o,
    output logic       rtc_ad_oe,
    input  logic [7:0] rtc_ad_i,
    output logic       rtc_cs_n,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic       rtc_a_d
);

    typedef enum logic [2:0] {
        S_IDLE, S_A_SET, S_A_STB, S_A_HOLD, S_D_SET, S_D_STB, S_D_HOLD
    } state_t;

    localparam logic [3:0] PH_LAST  = 4'(T_PH - 1);
    localparam logic [7:0] P_ADDR   = BASE;
    localparam logic [7:0] P_WDATA  = BASE + 8'd1;
    localparam logic [7:0] P_CMD    = BASE + 8'd2;
    localparam logic [7:0] P_STATUS = BASE + 8'd3;
    localparam logic [7:0] P_RDATA  = BASE + 8'd4;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic [7:0] r_addr;
    logic [7:0] r_rdata;
    logic [7:0] r_sh_addr;
    logic [7:0] r_sh_data;
    logic       r_sh_rd;
    logic       r_ovr;
    logic [7:0] r_in_port;

    logic [7:0] r_ad_o;
    logic       r_ad_oe;
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_a_d;

    logic [7:0] w_ad_o;
    logic       w_ad_oe;
    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic       w_a_d;

    logic       w_sel_addr;
    logic       w_sel_wdata;
    logic       w_sel_cmd;
    logic       w_sel_status;
    logic       w_sel_rdata;
    logic       w_busy;
    logic       w_start_req;
    logic       w_start;
    logic       w_ignored;
    logic [7:0] w_rd_mux;
    logic [7:0] w_sh_addr_nxt;
    logic [7:0] w_sh_data_nxt;
    logic       w_sh_rd_nxt;
    logic       w_unused_rd;

    // Reads are side-effect free, so the strobe is deliberately not used as a mux qualifier.
    assign w_unused_rd = read_strobe;

    assign w_sel_addr   = (port_id == P_ADDR);
    assign w_sel_wdata  = (port_id == P_WDATA);
    assign w_sel_cmd    = (port_id == P_CMD);
    assign w_sel_status = (port_id == P_STATUS);
    assign w_sel_rdata  = (port_id == P_RDATA);

    assign w_busy      = (r_state != S_IDLE);
    assign w_start_req = write_strobe & (w_sel_wdata | w_sel_cmd);
    assign w_start     = w_start_req & ~w_busy;
    assign w_ignored   = w_start_req & w_busy;

    // Shadow values as they will be after this edge; the registered bus outputs are
    // decoded from these so the bus moves in the same cycle as the state register.
    assign w_sh_addr_nxt = w_start ? r_addr : r_sh_addr;
    assign w_sh_data_nxt = (w_start && w_sel_wdata) ? out_port : r_sh_data;
    assign w_sh_rd_nxt   = w_start ? w_sel_cmd : r_sh_rd;

    always_comb begin
        w_rd_mux = 8'h00;
        if (w_sel_addr) begin
            w_rd_mux = r_addr;
        end else if (w_sel_status) begin
            w_rd_mux = {6'd0, r_ovr, w_busy};
        end else if (w_sel_rdata) begin
            w_rd_mux = r_rdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr    <= 8'h00;
            r_rdata   <= 8'h00;
            r_sh_addr <= 8'h00;
            r_sh_data <= 8'h00;
            r_sh_rd   <= 1'b0;
            r_ovr     <= 1'b0;
            r_in_port <= 8'h00;
        end else begin
            if (write_strobe && w_sel_addr) begin
                r_addr <= out_port;
            end
            r_sh_addr <= w_sh_addr_nxt;
            r_sh_data <= w_sh_data_nxt;
            r_sh_rd   <= w_sh_rd_nxt;
            // A rejected start outranks a STATUS clear in the same cycle.
            if (w_ignored) begin
                r_ovr <= 1'b1;
            end else if (write_strobe && w_sel_status) begin
                r_ovr <= 1'b0;
            end
            if (r_state == S_D_STB && r_cnt == 4'd0 && r_sh_rd) begin
                r_rdata <= rtc_ad_i;
            end
            r_in_port <= w_rd_mux;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == S_IDLE) begin
            if (w_start) begin
                w_state_nxt = S_A_SET;
                w_cnt_nxt   = PH_LAST;
            end
        end else if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
        end else begin
            w_cnt_nxt = PH_LAST;
            case (r_state)
                S_A_SET:  w_state_nxt = S_A_STB;
                S_A_STB:  w_state_nxt = S_A_HOLD;
                S_A_HOLD: w_state_nxt = S_D_SET;
                S_D_SET:  w_state_nxt = S_D_STB;
                S_D_STB:  w_state_nxt = S_D_HOLD;
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_cs_n  = 1'b1;
        w_rd_n  = 1'b1;
        w_wr_n  = 1'b1;
        w_a_d   = 1'b0;
        w_ad_oe = 1'b0;
        w_ad_o  = 8'h00;
        case (w_state_nxt)
            S_A_SET, S_A_STB, S_A_HOLD: begin
                w_cs_n  = 1'b0;
                w_ad_oe = 1'b1;
                w_ad_o  = w_sh_addr_nxt;
                w_wr_n  = (w_state_nxt != S_A_STB);
            end
            S_D_SET, S_D_STB, S_D_HOLD: begin
                w_cs_n = 1'b0;
                w_a_d  = 1'b1;
                if (w_sh_rd_nxt) begin
                    // Bus released for the whole data phase so the RTC can drive it.
                    w_rd_n = (w_state_nxt != S_D_STB);
                end else begin
                    w_ad_oe = 1'b1;
                    w_ad_o  = w_sh_data_nxt;
                    w_wr_n  = (w_state_nxt != S_D_STB);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_a_d   <= 1'b0;
            r_ad_oe <= 1'b0;
            r_ad_o  <= 8'h00;
        end else begin
            r_cs_n  <= w_cs_n;
            r_rd_n  <= w_rd_n;
            r_wr_n  <= w_wr_n;
            r_a_d   <= w_a_d;
            r_ad_oe <= w_ad_oe;
            r_ad_o  <= w_ad_o;
        end
    end

    assign in_port   = r_in_port;
    assign rtc_cs_n  = r_cs_n;
    assign rtc_rd_n  = r_rd_n;
    assign rtc_wr_n  = r_wr_n;
    assign rtc_a_d   = r_a_d;
    assign rtc_ad_oe = r_ad_oe;
    assign rtc_ad_o  = r_ad_o;

endmodule

// File: tb/tb_rtc_bus_bridge.sv
// tb/tb_rtc_bus_bridge.sv - scoreboard bench for rtc_bus_bridge at T_PH=4 and T_PH=1
module tb_rtc_bus_bridge;

    localparam logic [7:0] BASE = 8'h10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i    [2];
    logic [7:0] port_id  [2];
    logic [7:0] out_port [2];
    logic       ws       [2];
    logic       rs       [2];
    logic [7:0] in_port  [2];
    logic [7:0] ad_o     [2];
    logic       oe       [2];
    logic [7:0] ad_i     [2];
    logic       cs_n     [2];
    logic       rd_n     [2];
    logic       wr_n     [2];
    logic       a_d      [2];

    rtc_bus_bridge #(.T_PH(4), .BASE(BASE)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i[0]), .port_id(port_id[0]), .out_port(out_port[0]),
        .write_strobe(ws[0]), .read_strobe(rs[0]), .in_port(in_port[0]),
        .rtc_ad_o(ad_o[0]), .rtc_ad_oe(oe[0]), .rtc_ad_i(ad_i[0]), .rtc_cs_n(cs_n[0]),
        .rtc_rd_n(rd_n[0]), .rtc_wr_n(wr_n[0]), .rtc_a_d(a_d[0])
    );

    rtc_bus_bridge #(.T_PH(1), .BASE(BASE)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i[1]), .port_id(port_id[1]), .out_port(out_port[1]),
        .write_strobe(ws[1]), .read_strobe(rs[1]), .in_port(in_port[1]),
        .rtc_ad_o(ad_o[1]), .rtc_ad_oe(oe[1]), .rtc_ad_i(ad_i[1]), .rtc_cs_n(cs_n[1]),
        .rtc_rd_n(rd_n[1]), .rtc_wr_n(wr_n[1]), .rtc_a_d(a_d[1])
    );

    typedef struct {
        int         d;
        logic [7:0] addr;
        logic [7:0] data;
        logic       is_rd;
    } txn_t;

    typedef struct {
        int         d;
        logic [7:0] val;
        string      name;
    } rd_t;

    txn_t exp_q[$];
    rd_t  rd_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register contents plus the cycle windows derived from 6*T_PH.
    logic [7:0] m_addr    [2];
    logic       m_ovr     [2];
    int         busy_until[2];
    logic [7:0] m_rd_old  [2];
    logic [7:0] m_rd_new  [2];
    int         m_rd_time [2];

    function automatic int tp(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] rdata_at(int d, int m);
        return (m >= m_rd_time[d]) ? m_rd_new[d] : m_rd_old[d];
    endfunction

    // Value the bridge registers for port id pid, given registers as they stand after edge m.
    function automatic logic [7:0] exp_rd(int d, logic [7:0] pid, int m);
        if (pid == BASE) return m_addr[d];
        if (pid == BASE + 8'd3) return {6'd0, m_ovr[d], (m <= busy_until[d])};
        if (pid == BASE + 8'd4) return rdata_at(d, m);
        return 8'h00;
    endfunction

    task automatic model_reset(int d);
        m_addr[d]     = 8'h00;
        m_ovr[d]      = 1'b0;
        busy_until[d] = -100;
        m_rd_old[d]   = 8'h00;
        m_rd_new[d]   = 8'h00;
        m_rd_time[d]  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(int d);
        while (cyc <= busy_until[d]) tick();
    endtask

    task automatic wr(int d, logic [7:0] off, logic [7:0] val, logic [7:0] rv);
        int   m;
        txn_t t;
        m = cyc;
        port_id[d]  = BASE + off;
        out_port[d] = val;
        ws[d]       = 1'b1;
        if (off == 8'd0) begin
            m_addr[d] = val;
        end else if (off == 8'd3) begin
            m_ovr[d] = 1'b0;
        end else if (off == 8'd1 || off == 8'd2) begin
            if (m > busy_until[d]) begin
                t.d     = d;
                t.addr  = m_addr[d];
                t.is_rd = (off == 8'd2);
                t.data  = (off == 8'd2) ? rv : val;
                exp_q.push_back(t);
                busy_until[d] = m + 6 * tp(d);
                if (off == 8'd2) begin
                    m_rd_old[d]  = rdata_at(d, m);
                    m_rd_new[d]  = rv;
                    m_rd_time[d] = m + 1 + 4 * tp(d);
                    ad_i[d]      = rv;
                end
            end else begin
                m_ovr[d] = 1'b1;
            end
        end
        tick();
        ws[d] = 1'b0;
    endtask

    task automatic rd(int d, logic [7:0] pid, string nm);
        rd_t r;
        port_id[d] = pid;
        r.d    = d;
        r.val  = exp_rd(d, pid, cyc);
        r.name = nm;
        rd_q.push_back(r);
        tick();
        rs[d] = 1'b1;
        tick();
        rs[d] = 1'b0;
    endtask

    // Assert reset mid-cycle so the bus must drop before any clock edge.
    task automatic async_reset(int d);
        @(posedge clk);
        #2;
        rst_i[d] = 1'b1;
        model_reset(d);
        tick();
        tick();
        rst_i[d] = 1'b0;
    endtask

    task automatic reset_in_dstb(int d);
        int n;
        wr(d, 8'd0, 8'($urandom), 8'h00);
        n = cyc;
        wr(d, 8'd1, 8'($urandom), 8'h00);
        while (cyc < n + 3 * tp(d)) tick();
        async_reset(d);
        rd(d, BASE + 8'd3, "status_after_reset");
        rd(d, BASE, "addr_after_reset");
        rd(d, BASE + 8'd4, "rdata_after_reset");
    endtask

    task automatic random_ops(int d, int n_ops);
        for (int i = 0; i < n_ops; i++) begin
            int         r;
            logic [7:0] pid;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1: wr(d, 8'd0, 8'($urandom), 8'h00);
                2, 3: wr(d, 8'd1, 8'($urandom), 8'h00);
                4, 5: wr(d, 8'd2, 8'($urandom), 8'($urandom));
                6:    wr(d, 8'd3, 8'($urandom), 8'h00);
                7, 8: begin
                    case ($urandom_range(0, 2))
                        0:       pid = BASE + 8'($urandom_range(0, 5));
                        1:       pid = 8'h30;
                        default: pid = 8'($urandom);
                    endcase
                    rd(d, pid, "rand_read");
                end
                default: repeat (int'($urandom_range(1, 8 * tp(d)))) tick();
            endcase
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_i[d]    = 1'b1;
            port_id[d]  = 8'h00;
            out_port[d] = 8'h00;
            ws[d]       = 1'b0;
            rs[d]       = 1'b0;
            ad_i[d]     = 8'h00;
            model_reset(d);
        end
        repeat (3) tick();
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;
        tick();

        rd(0, BASE, "reset_addr");
        rd(0, BASE + 8'd3, "reset_status");
        rd(0, BASE + 8'd4, "reset_rdata");

        wr(0, 8'd0, 8'h21, 8'h00);
        wr(0, 8'd1, 8'h45, 8'h00);
        rd(0, BASE + 8'd3, "status_busy");
        wait_idle(0);
        rd(0, BASE + 8'd3, "status_idle");

        wr(0, 8'd0, 8'h05, 8'h00);
        wr(0, 8'd2, 8'h00, 8'h59);
        wait_idle(0);
        rd(0, BASE + 8'd4, "rdata_59");

        wr(0, 8'd1, 8'h33, 8'h00);
        repeat (2) tick();
        wr(0, 8'd1, 8'h77, 8'h00);
        rd(0, BASE + 8'd3, "status_ovr_busy");
        wait_idle(0);
        rd(0, BASE + 8'd3, "status_ovr_idle");
        wr(0, 8'd3, 8'h00, 8'h00);
        rd(0, BASE + 8'd3, "status_cleared");

        reset_in_dstb(0);
        random_ops(0, 80);
        wait_idle(0);

        wr(1, 8'd0, 8'h3c, 8'h00);
        wr(1, 8'd1, 8'ha5, 8'h00);
        wait_idle(1);
        wr(1, 8'd2, 8'h00, 8'hc3);
        wait_idle(1);
        rd(1, BASE + 8'd4, "t1_rdata");
        rd(1, 8'h30, "unmapped_30");
        reset_in_dstb(1);
        random_ops(1, 80);
        wait_idle(1);

        repeat (4) tick();
        stim_done = 1'b1;
    end

    // Monitor state, one slot per DUT.
    int         len      [2];
    int         a_len    [2];
    int         a_stb_n  [2];
    int         a_stb_pos[2];
    int         d_wr_cnt [2];
    int         d_rd_cnt [2];
    int         d_stb_pos[2];
    int         d_oe_cnt [2];
    logic [7:0] a_val    [2];
    logic [7:0] d_val    [2];
    bit         a_bad    [2];
    bit         d_bad    [2];
    bit         fin = 1'b0;

    function automatic bit bus_idle(int d);
        return cs_n[d] && rd_n[d] && wr_n[d] && !a_d[d] && !oe[d] && (ad_o[d] == 8'h00);
    endfunction

    task automatic clear_trk(int d);
        len[d] = 0; a_len[d] = 0; a_stb_n[d] = 0; a_stb_pos[d] = -1;
        d_wr_cnt[d] = 0; d_rd_cnt[d] = 0; d_stb_pos[d] = -1; d_oe_cnt[d] = 0;
        a_val[d] = 8'h00; d_val[d] = 8'h00; a_bad[d] = 1'b0; d_bad[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        txn_t e;
        rd_t  r;
        int   t;
        int   pos;
        bit   ok;
        for (int d = 0; d < 2; d++) begin
            t = tp(d);
            if (rst_i[d]) begin
                n_chk++;
                if (!bus_idle(d) || in_port[d] != 8'h00) begin
                    n_err++;
                    $display("FAIL reset_outputs dut%0d: cs_n=%b rd_n=%b wr_n=%b a_d=%b oe=%b ad_o=%h in_port=%h required idle bus and in_port 00",
                             d, cs_n[d], rd_n[d], wr_n[d], a_d[d], oe[d], ad_o[d], in_port[d]);
                end
                if (len[d] > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
                clear_trk(d);
            end else if (!cs_n[d]) begin
                pos = len[d];
                len[d]++;
                n_chk++;
                if ((!rd_n[d] && !wr_n[d]) || (oe[d] && !rd_n[d])) begin
                    n_err++;
                    $display("FAIL strobe_conflict dut%0d: rd_n=%b wr_n=%b oe=%b", d, rd_n[d], wr_n[d], oe[d]);
                end
                if (!a_d[d]) begin
                    if (pos != a_len[d]) a_bad[d] = 1'b1;
                    if (a_len[d] == 0) a_val[d] = ad_o[d];
                    else if (ad_o[d] != a_val[d]) a_bad[d] = 1'b1;
                    if (!oe[d] || !rd_n[d]) a_bad[d] = 1'b1;
                    if (!wr_n[d]) begin
                        if (a_stb_n[d] == 0) a_stb_pos[d] = pos;
                        a_stb_n[d]++;
                    end
                    a_len[d]++;
                end else begin
                    if (oe[d]) begin
                        d_oe_cnt[d]++;
                        if (d_oe_cnt[d] == 1) d_val[d] = ad_o[d];
                        else if (ad_o[d] != d_val[d]) d_bad[d] = 1'b1;
                    end
                    if ((!wr_n[d] || !rd_n[d]) && d_wr_cnt[d] + d_rd_cnt[d] == 0) d_stb_pos[d] = pos;
                    if (!wr_n[d]) d_wr_cnt[d]++;
                    if (!rd_n[d]) d_rd_cnt[d]++;
                end
            end else begin
                n_chk++;
                if (!bus_idle(d)) begin
                    n_err++;
                    $display("FAIL idle_outputs dut%0d: rd_n=%b wr_n=%b a_d=%b oe=%b ad_o=%h required 1 1 0 0 00",
                             d, rd_n[d], wr_n[d], a_d[d], oe[d], ad_o[d]);
                end
                if (len[d] > 0) begin
                    n_chk++;
                    if (exp_q.size() == 0 || exp_q[0].d != d) begin
                        n_err++;
                        $display("FAIL unexpected_txn dut%0d: bus transaction with no matching expectation", d);
                    end else begin
                        e = exp_q.pop_front();
                        if (len[d] != 6 * t || a_len[d] != 3 * t) begin
                            n_err++;
                            $display("FAIL txn_len dut%0d: cs_n low %0d, addr phase %0d; required %0d, %0d",
                                     d, len[d], a_len[d], 6 * t, 3 * t);
                        end
                        n_chk++;
                        if (a_bad[d] || a_val[d] != e.addr || a_stb_n[d] != t || a_stb_pos[d] != t) begin
                            n_err++;
                            $display("FAIL addr_phase dut%0d: ad_o=%h wr_n low %0d at %0d bad=%b; required ad_o=%h wr_n low %0d at %0d",
                                     d, a_val[d], a_stb_n[d], a_stb_pos[d], a_bad[d], e.addr, t, t);
                        end
                        n_chk++;
                        if (e.is_rd) ok = (d_rd_cnt[d] == t) && (d_wr_cnt[d] == 0) && (d_stb_pos[d] == 4 * t) && (d_oe_cnt[d] == 0);
                        else ok = (d_wr_cnt[d] == t) && (d_rd_cnt[d] == 0) && (d_stb_pos[d] == 4 * t) &&
                                  (d_oe_cnt[d] == 3 * t) && (d_val[d] == e.data) && !d_bad[d];
                        if (!ok) begin
                            n_err++;
                            $display("FAIL data_phase dut%0d rd=%b: wr_n low %0d rd_n low %0d at %0d oe %0d ad_o=%h; required strobe %0d at %0d oe %0d ad_o=%h",
                                     d, e.is_rd, d_wr_cnt[d], d_rd_cnt[d], d_stb_pos[d], d_oe_cnt[d], d_val[d],
                                     t, 4 * t, e.is_rd ? 0 : 3 * t, e.data);
                        end
                    end
                    clear_trk(d);
                end
            end
            if (rs[d]) begin
                n_chk++;
                if (rd_q.size() == 0 || rd_q[0].d != d) begin
                    n_err++;
                    $display("FAIL read_queue dut%0d: read strobe with no matching expectation", d);
                end else begin
                    r = rd_q.pop_front();
                    if (in_port[d] != r.val) begin
                        n_err++;
                        $display("FAIL %s dut%0d: in_port=%h required %h", r.name, d, in_port[d], r.val);
                    end
                end
            end
        end
        if (stim_done && !fin) begin
            fin = 1'b1;
            n_chk++;
            if (exp_q.size() != 0 || rd_q.size() != 0) begin
                n_err++;
                $display("FAIL leftover: %0d transactions and %0d reads never observed, required 0 and 0",
                         exp_q.size(), rd_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: stimulus did not complete within 50000 cycles");
        $fatal(1);
    end

endmodule
